// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a DEPTH-entry {pc, word} buffer
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0040_0000),
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, addr, target;
  logic hold, stale, accept, push, pop;
  logic [AW-1:0] rp, wp;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [31:0] word_mem [DEPTH];
  always_comb begin
    target = redirect_target & ~ADDR_W'(3);
    imem_req_valid = !reset && state == S_REQ && (hold || count < CW'(DEPTH));
    imem_req_addr = hold ? addr : pc;
    accept = imem_req_valid && imem_req_ready;
    push = state == S_WAIT && imem_rsp_valid && !redirect_valid;
    inst_valid = count != '0;
    pop = inst_valid && inst_ready && !redirect_valid;
    inst_data = inst_valid ? word_mem[rp] : '0;
    inst_pc = inst_valid ? pc_mem[rp] : '0;
    state_n = state == S_REQ  ? (accept ? ((redirect_valid || stale) ? S_DROP : S_WAIT) : S_REQ) :
              state == S_WAIT ? (imem_rsp_valid ? S_REQ : (redirect_valid ? S_DROP : S_WAIT)) :
                                (imem_rsp_valid ? S_REQ : S_DROP);
  end
  // a request still in flight across reset must have its response swallowed afterwards
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (state != S_REQ && !imem_rsp_valid) ? S_DROP : S_REQ;
      pc <= RESET_VECTOR;
      count <= '0;
      rp <= '0;
      wp <= '0;
      hold <= 1'b0;
      stale <= 1'b0;
    end else begin
      state <= state_n;
      pc <= redirect_valid ? target : (accept && !stale) ? pc + ADDR_W'(4) : pc;
      hold <= imem_req_valid && !imem_req_ready;
      stale <= imem_req_valid && !imem_req_ready && (stale || redirect_valid);
      rp <= pop ? rp + AW'(1) : rp;
      wp <= redirect_valid ? rp : push ? wp + AW'(1) : wp;
      count <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (imem_req_valid && !hold) addr <= pc;
    if (push) begin
      pc_mem[wp] <= addr;
      word_mem[wp] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-programmable memory model
module tb_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;
  int total = 0, bad = 0;
  int lat = 1, cnt = 0;
  bit pend = 0;
  logic [31:0] paddr = '0;

  fetch_unit dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clock = ~clock;

  // memory answers each accepted request 'lat' cycles later with ~address
  always @(negedge clock) begin
    imem_rsp_valid = 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = ~paddr;
        pend = 0;
      end else cnt--;
    end
    if (imem_req_valid && imem_req_ready) begin
      pend = 1;
      paddr = imem_req_addr;
      cnt = lat;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) step();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0040_0000);
    step(); #1;
    chk("wait_no_req", 32'(imem_req_valid), 32'd0);
    step(); #1;
    chk("req2_addr", imem_req_addr, 32'h0040_0004);
    chk("head_valid", 32'(inst_valid), 32'd1);
    chk("head_pc0", inst_pc, 32'h0040_0000);
    chk("head_data0", inst_data, ~32'h0040_0000);
    repeat (2) step(); #1;
    chk("req3_addr", imem_req_addr, 32'h0040_0008);
    repeat (4) step(); #1;
    chk("full_no_req", 32'(imem_req_valid), 32'd0);
    chk("full_head_pc", inst_pc, 32'h0040_0000);
    step(); #1;
    chk("full_no_req2", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    #1;
    chk("pop_head_pc", inst_pc, 32'h0040_0004);
    chk("refill_req", 32'(imem_req_valid), 32'd1);
    chk("refill_addr", imem_req_addr, 32'h0040_0010);
    step(); step(); #1;
    chk("refull_no_req", 32'(imem_req_valid), 32'd0);
    step(); #1;
    chk("refull_no_req2", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    lat = 3;
    step();
    inst_ready = 1'b0;
    #1;
    chk("req_0x14", imem_req_addr, 32'h0040_0014);
    chk("head_pc_08", inst_pc, 32'h0040_0008);
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0103;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("flush_inst_valid", 32'(inst_valid), 32'd0);
    chk("drop_no_req", 32'(imem_req_valid), 32'd0);
    step(); #1;
    chk("drop_no_req2", 32'(imem_req_valid), 32'd0);
    lat = 1;
    step(); #1;
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h0040_0100);
    chk("redir_empty", 32'(inst_valid), 32'd0);
    step(); step(); #1;
    chk("redir_head_pc", inst_pc, 32'h0040_0100);
    chk("redir_head_data", inst_data, ~32'h0040_0100);
    chk("redir_next_addr", imem_req_addr, 32'h0040_0104);
    imem_req_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      redirect_valid = (i == 2);
      redirect_target = 32'h0040_0200;
      #1;
      chk("stall_addr", imem_req_addr, 32'h0040_0104);
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
    end
    chk("stall_flushed", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
    step(); #1;
    chk("stale_drop_no_req", 32'(imem_req_valid), 32'd0);
    step(); #1;
    chk("post_stall_addr", imem_req_addr, 32'h0040_0200);
    chk("post_stall_empty", 32'(inst_valid), 32'd0);
    step(); step(); #1;
    chk("post_stall_pc", inst_pc, 32'h0040_0200);
    chk("post_stall_next", imem_req_addr, 32'h0040_0204);
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("acc_redir_drop", 32'(imem_req_valid), 32'd0);
    chk("acc_redir_empty", 32'(inst_valid), 32'd0);
    step(); #1;
    chk("top_addr", imem_req_addr, 32'hFFFF_FFFC);
    step(); step(); #1;
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    chk("wrap_head_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_head_data", inst_data, 32'h0000_0003);
    repeat (4) step();
    lat = 3;
    #1;
    chk("pre_rst_addr", imem_req_addr, 32'h0000_0008);
    chk("pre_rst_head", inst_pc, 32'hFFFF_FFFC);
    step();
    reset = 1'b1;
    #1;
    chk("in_rst_no_req", 32'(imem_req_valid), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("after_rst_empty", 32'(inst_valid), 32'd0);
    chk("after_rst_drop", 32'(imem_req_valid), 32'd0);
    step(); #1;
    chk("late_rsp_no_req", 32'(imem_req_valid), 32'd0);
    lat = 1;
    step(); #1;
    chk("restart_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_addr", imem_req_addr, 32'h0040_0000);
    chk("restart_empty", 32'(inst_valid), 32'd0);
    step(); step(); #1;
    chk("restart_head_valid", 32'(inst_valid), 32'd1);
    chk("restart_head_pc", inst_pc, 32'h0040_0000);
    chk("restart_head_data", inst_data, ~32'h0040_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
